// File: rtl/koa_sched_pkg.sv
// rtl/koa_sched_pkg.sv - shared encodings and constants for the Karatsuba multiplier scheduler
package koa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } sched_state_e;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  localparam int DEFAULT_LAT = 2;

endpackage

// File: rtl/koa_mult_sched_rr_arb2.sv
// rtl/koa_mult_sched_rr_arb2.sv - two-input round-robin arbiter, pointer advances on accept
module rr_arb2
  import koa_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // ptr_q=0 favours requester 0, ptr_q=1 favours requester 1
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (req_i[REQ0] && (!ptr_q || !req_i[REQ1])) begin
      gnt_o[REQ0] = 1'b1;
    end else if (req_i[REQ1]) begin
      gnt_o[REQ1] = 1'b1;
    end
    if (accept_i) begin
      ptr_d = gnt_o[REQ0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/koa_mult_sched.sv
// rtl/koa_mult_sched.sv - shares one registered-output significand multiplier between two requesters
module koa_mult_sched
  import koa_sched_pkg::*;
#(
  parameter int SW  = 24,
  parameter int LAT = DEFAULT_LAT,
  parameter int CW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [SW-1:0]   req0_a_i,
  input  logic [SW-1:0]   req0_b_i,
  input  logic [SW-1:0]   req1_a_i,
  input  logic [SW-1:0]   req1_b_i,
  output logic [1:0]      rsp_valid_o,
  input  logic [1:0]      rsp_ready_i,
  output logic [2*SW-1:0] rsp_data_o,
  output logic [SW-1:0]   mul_a_o,
  output logic [SW-1:0]   mul_b_o,
  output logic            mul_load_o,
  input  logic [2*SW-1:0] mul_result_i,
  output logic            busy_o
);

  if (LAT < 1 || LAT >= (1 << CW)) begin : g_bad_lat
    $error("koa_mult_sched: LAT must be in [1, 2**CW-1]");
  end

  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]    gnt;
  logic          accept;

  assign accept = (state_q == IDLE) && (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid_i),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    mul_load_o  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = gnt;
        if (accept) begin
          owner_d = gnt[REQ1];
          a_d     = gnt[REQ1] ? req1_a_i : req0_a_i;
          b_d     = gnt[REQ1] ? req1_b_i : req0_b_i;
          cnt_d   = CW'(1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // operands have been stable for LAT cycles once the counter reaches LAT
        if (cnt_q == LAT_C) begin
          mul_load_o = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign mul_a_o    = a_q;
  assign mul_b_o    = b_q;
  assign rsp_data_o = mul_result_i;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_koa_mult_sched.sv
// tb/tb_koa_mult_sched.sv - self-checking bench for koa_mult_sched
module tb_koa_mult_sched;

  localparam int SW  = 24;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid_i = 2'b00;
  logic [1:0]    req_ready_o;
  logic [SW-1:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
  logic [1:0]    rsp_valid_o;
  logic [1:0]    rsp_ready_i = 2'b00;
  logic [47:0]   rsp_data_o;
  logic [SW-1:0] mul_a_o, mul_b_o;
  logic          mul_load_o;
  logic [47:0]   mul_result_i = '0;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  koa_mult_sched #(.SW(SW), .LAT(LAT), .CW(CW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_load_o   (mul_load_o),
    .mul_result_i (mul_result_i),
    .busy_o       (busy_o)
  );

  // exact multiplier with a product register loaded by mul_load_o
  always @(posedge clk) if (mul_load_o) mul_result_i <= 48'(mul_a_o) * 48'(mul_b_o);

  // LAT sweep instances
  logic [1:0]  s_valid [2], s_ready [2], s_rv [2], s_rr [2];
  logic [23:0] s_a [2], s_b [2], s_ma [2], s_mb [2];
  logic [47:0] s_data [2];
  logic        s_load [2], s_busy [2];

  for (genvar k = 0; k < 2; k++) begin : g_sweep
    localparam int LK = (k == 0) ? 1 : 5;
    logic [47:0] res = '0;
    koa_mult_sched #(.SW(24), .LAT(LK), .CW(4)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (s_valid[k]),
      .req_ready_o  (s_ready[k]),
      .req0_a_i     (s_a[k]),
      .req0_b_i     (s_b[k]),
      .req1_a_i     (24'h0),
      .req1_b_i     (24'h0),
      .rsp_valid_o  (s_rv[k]),
      .rsp_ready_i  (s_rr[k]),
      .rsp_data_o   (s_data[k]),
      .mul_a_o      (s_ma[k]),
      .mul_b_o      (s_mb[k]),
      .mul_load_o   (s_load[k]),
      .mul_result_i (res),
      .busy_o       (s_busy[k])
    );
    always @(posedge clk) if (s_load[k]) res <= 48'(s_ma[k]) * 48'(s_mb[k]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Transaction-level reference: an accepted op owns the multiplier for a fixed
  // timeline measured from its accept edge; load at LAT, response from LAT+1.
  bit          m_busy = 0, m_own = 0, m_fav = 0;
  int          m_el = 0;
  bit [SW-1:0] m_a = '0, m_b = '0;
  bit [1:0]    m_acc = 2'b00;
  logic [1:0]  m_w;

  function automatic logic [1:0] m_win(input logic [1:0] v, input bit fav);
    if (v == 2'b11) return fav ? 2'b10 : 2'b01;
    return v;
  endfunction

  assign m_w = m_busy ? 2'b00 : m_win(req_valid_i, m_fav);

  always @(posedge clk) begin
    m_acc <= 2'b00;
    if (rst) begin
      m_busy <= 0; m_fav <= 0; m_a <= '0; m_b <= '0; m_el <= 0;
    end else if (!m_busy) begin
      if (m_w != 2'b00) begin
        m_busy <= 1;
        m_el   <= 1;
        m_own  <= m_w[1];
        m_fav  <= ~m_w[1];
        m_acc  <= m_w;
        m_a    <= m_w[1] ? req1_a_i : req0_a_i;
        m_b    <= m_w[1] ? req1_b_i : req0_b_i;
      end
    end else if (m_el > LAT && rsp_ready_i[m_own]) begin
      m_busy <= 0;
    end else begin
      m_el <= m_el + 1;
    end
  end

  always @(negedge clk) begin
    chk("m_req_ready", req_ready_o, m_w);
    chk("m_mul_load", mul_load_o, (m_busy && m_el == LAT));
    chk("m_busy", busy_o, m_busy);
    chk("m_rsp_valid", rsp_valid_o, (m_busy && m_el > LAT) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
    chk("m_mul_a", mul_a_o, m_a);
    chk("m_mul_b", mul_b_o, m_b);
    if (m_busy && m_el > LAT) chk("m_rsp_data", rsp_data_o, 48'(m_a) * 48'(m_b));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b00;
    cyc();
    cyc();
    samp();
    chk("rst_req_ready", req_ready_o, 2'b00);
    chk("rst_rsp_valid", rsp_valid_o, 2'b00);
    chk("rst_mul_load", mul_load_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mul_a", mul_a_o, 24'h0);
    chk("rst_mul_b", mul_b_o, 24'h0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [1:0] exp_v, input logic [47:0] exp_d);
    int n;
    n = 0;
    samp();
    while (rsp_valid_o == 2'b00 && n < 20) begin
      cyc();
      samp();
      n++;
    end
    chk({name, "_valid"}, rsp_valid_o, exp_v);
    chk({name, "_data"}, rsp_data_o, exp_d);
  endtask

  task automatic sweep(input int k, input int lat);
    int load_at, rsp_at, bad;
    load_at = -1; rsp_at = -1; bad = 0;
    s_a[k] = 24'h123456; s_b[k] = 24'h654321; s_valid[k] = 2'b01; s_rr[k] = 2'b11;
    samp();
    chk($sformatf("sweep%0d_ready", lat), s_ready[k], 2'b01);
    cyc();
    s_valid[k] = 2'b00;
    for (int c = 1; c <= lat + 3; c++) begin
      samp();
      if (s_load[k] && load_at < 0) load_at = c;
      if (s_rv[k] != 2'b00 && rsp_at < 0) begin
        rsp_at = c;
        chk($sformatf("sweep%0d_rsp_valid", lat), s_rv[k], 2'b01);
        chk($sformatf("sweep%0d_rsp_data", lat), s_data[k], 48'h07336BF94116);
      end
      if (c <= lat + 1 && (s_ma[k] !== 24'h123456 || s_mb[k] !== 24'h654321)) bad++;
      cyc();
    end
    chk($sformatf("sweep%0d_load_cycle", lat), load_at, lat);
    chk($sformatf("sweep%0d_rsp_cycle", lat), rsp_at, lat + 1);
    chk($sformatf("sweep%0d_operands_stable", lat), bad, 0);
  endtask

  function automatic logic [23:0] rnd24();
    case ($urandom_range(0, 4))
      0:       return 24'hFFFFFF;
      1:       return 24'h000000;
      2:       return 24'h800000;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [1:0]    pend;
    logic [23:0] ra [2];
    logic [23:0] rb [2];
    int          bad;

    for (int k = 0; k < 2; k++) begin
      s_valid[k] = 2'b00; s_rr[k] = 2'b00; s_a[k] = '0; s_b[k] = '0;
    end

    // single request, full-scale operands
    do_reset();
    req_valid_i = 2'b01; req0_a_i = 24'hFFFFFF; req0_b_i = 24'hFFFFFF; rsp_ready_i = 2'b11;
    samp(); chk("single_ready_c0", req_ready_o, 2'b01);
    cyc(); req_valid_i = 2'b00;
    samp(); chk("single_load_c1", mul_load_o, 1'b0); chk("single_busy_c1", busy_o, 1'b1);
    cyc(); samp(); chk("single_load_c2", mul_load_o, 1'b1);
    cyc(); samp();
    chk("single_rsp_valid_c3", rsp_valid_o, 2'b01);
    chk("single_rsp_data_c3", rsp_data_o, 48'hFFFFFE000001);
    cyc(); samp(); chk("single_idle_c4", busy_o, 1'b0);
    cyc();

    // contention, then round-robin hand-off
    do_reset();
    req_valid_i = 2'b11; rsp_ready_i = 2'b11;
    req0_a_i = 24'h800000; req0_b_i = 24'h000002;
    req1_a_i = 24'h000003; req1_b_i = 24'h000005;
    samp(); chk("cont_first_r0", req_ready_o, 2'b01);
    cyc(); req0_a_i = 24'h000007; req0_b_i = 24'h000009;
    wait_rsp("cont_r0", 2'b01, 48'h000001000000);
    cyc(); samp(); chk("cont_next_r1", req_ready_o, 2'b10);
    cyc(); req_valid_i[1] = 1'b0;
    wait_rsp("cont_r1", 2'b10, 48'h00000000000F);
    cyc(); samp(); chk("cont_then_r0", req_ready_o, 2'b01);
    cyc(); req_valid_i = 2'b00;
    wait_rsp("cont_r0b", 2'b01, 48'h00000000003F);
    cyc();

    // backpressure in RESP
    do_reset();
    req_valid_i = 2'b01; req0_a_i = 24'h000ABC; req0_b_i = 24'h000100; rsp_ready_i = 2'b00;
    samp(); chk("bp_ready", req_ready_o, 2'b01);
    cyc(); req_valid_i = 2'b00;
    wait_rsp("bp_rsp", 2'b01, 48'h0000000ABC00);
    cyc();
    req_valid_i = 2'b10; req1_a_i = 24'h000011; req1_b_i = 24'h000011; rsp_ready_i = 2'b10;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      samp();
      if (rsp_valid_o !== 2'b01 || rsp_data_o !== 48'h0000000ABC00 ||
          mul_load_o !== 1'b0 || req_ready_o !== 2'b00) bad++;
      cyc();
    end
    chk("bp_stall_stable", bad, 0);
    rsp_ready_i = 2'b01;
    samp(); chk("bp_release_valid", rsp_valid_o, 2'b01);
    cyc(); samp();
    chk("bp_idle_busy", busy_o, 1'b0);
    chk("bp_idle_r1_ready", req_ready_o, 2'b10);
    cyc(); req_valid_i = 2'b00; rsp_ready_i = 2'b11;
    wait_rsp("bp_r1", 2'b10, 48'h000000000121);
    cyc();

    // reset while in SETTLE
    do_reset();
    req_valid_i = 2'b01; req0_a_i = 24'h111111; req0_b_i = 24'h000002; rsp_ready_i = 2'b11;
    samp(); chk("mrst_ready", req_ready_o, 2'b01);
    cyc(); req_valid_i = 2'b00; rst = 1'b1;
    cyc(); rst = 1'b0;
    samp();
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_mul_a", mul_a_o, 24'h0);
    chk("mrst_mul_b", mul_b_o, 24'h0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (mul_load_o !== 1'b0 || rsp_valid_o !== 2'b00 || busy_o !== 1'b0) bad++;
      cyc();
      samp();
    end
    chk("mrst_no_activity", bad, 0);
    cyc();

    // LAT sweep
    sweep(0, 1);
    sweep(1, 5);

    // randomized traffic against the reference
    pend = 2'b00;
    for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_acc[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          ra[i] = rnd24();
          rb[i] = rnd24();
        end
      end
      req_valid_i = pend;
      req0_a_i = ra[0]; req0_b_i = rb[0];
      req1_a_i = ra[1]; req1_b_i = rb[1];
      rsp_ready_i = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      rst = ($urandom_range(0, 249) == 0);
      cyc();
    end
    rst = 1'b0; req_valid_i = 2'b00; rsp_ready_i = 2'b11;
    for (int i = 0; i < 20; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
